// File: rtl/fullchip_inst_seq.sv
// rtl/fullchip_inst_seq.sv - fullchip instruction sequencer (KLOAD/EXEC/OFIFO/SFP), optional SEQ_PERF_CNT_EN cycle counter
module fullchip_inst_seq #(
   parameter int COL    = 8,
   parameter int ADDR_W = 4,
   parameter int GAP    = 10,
   parameter int INST_W = 20
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_start,
   input  logic [3:0]        i_phase_en,
   input  logic [ADDR_W:0]   i_n_vec,
   input  logic              i_stall,
   output logic [INST_W-1:0] o_inst,
   output logic              o_busy,
   output logic              o_done,
   output logic [2:0]        o_state
`ifdef SEQ_PERF_CNT_EN
   ,
   output logic [15:0]       o_cycle_cnt
`endif
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_KLOAD = 3'd1,
      S_EXEC  = 3'd2,
      S_OFIFO = 3'd3,
      S_SFP   = 3'd4,
      S_GAP   = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   localparam logic [ADDR_W:0] MAX_V   = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [15:0]     L_COL   = 16'(COL);
   localparam logic [15:0]     L_KLAST = 16'(COL + 1);
   localparam logic [15:0]     L_GLAST = 16'(GAP - 1);

   state_t              r_state, r_pend, w_state, w_pend, w_q;
   logic [15:0]         r_cnt, w_cnt, w_nlast;
   logic [2:0]          r_slot, w_slot;
   logic [3:0]          r_en, w_en, w_act, w_act_in;
   logic [ADDR_W:0]     r_n, w_n, w_nc;
   logic [INST_W-1:0]   r_inst, w_dec;
   logic [3:0]          w_qk, w_pm;
   logic                w_hold, w_end;

   // Lowest-numbered active phase at or after 'from' (phase p is state p+1).
   function automatic state_t f_next(input logic [2:0] from, input logic [3:0] act);
      state_t s;
      s = S_DONE;
      for (int p = 3; p >= 0; p--) begin
         if (p >= int'(from) && act[p]) s = state_t'(3'(p + 1));
      end
      return s;
   endfunction

   always_comb begin
      w_state  = r_state;
      w_pend   = r_pend;
      w_cnt    = r_cnt;
      w_slot   = r_slot;
      w_en     = r_en;
      w_n      = r_n;
      w_end    = 1'b0;
      w_nc     = (i_n_vec > MAX_V) ? MAX_V : i_n_vec;
      w_act    = {r_en[3:1] & {3{r_n != '0}}, r_en[0]};
      w_act_in = {i_phase_en[3:1] & {3{w_nc != '0}}, i_phase_en[0]};
      w_nlast  = 16'(r_n) - 16'd1;
      w_q      = f_next(r_state, w_act);
      w_hold   = i_stall && (r_state != S_IDLE) && (r_state != S_DONE);
      if (!w_hold) begin
         case (r_state)
            S_IDLE: if (i_start) begin
               w_en    = i_phase_en;
               w_n     = w_nc;
               w_cnt   = '0;
               w_slot  = '0;
               w_state = f_next(3'd0, w_act_in);
            end
            S_KLOAD: if (r_cnt == L_KLAST) w_end = 1'b1; else w_cnt = r_cnt + 16'd1;
            S_EXEC, S_OFIFO: if (r_cnt == w_nlast) w_end = 1'b1; else w_cnt = r_cnt + 16'd1;
            S_SFP: if (r_slot == 3'd5) begin
               w_slot = '0;
               if (r_cnt == w_nlast) w_end = 1'b1; else w_cnt = r_cnt + 16'd1;
            end else begin
               w_slot = r_slot + 3'd1;
            end
            S_GAP: if (r_cnt == L_GLAST) begin
               w_state = r_pend;
               w_cnt   = '0;
            end else begin
               w_cnt = r_cnt + 16'd1;
            end
            default: w_state = S_IDLE;
         endcase
         if (w_end) begin
            w_cnt  = '0;
            w_slot = '0;
            if (w_q == S_DONE) begin
               w_state = S_DONE;
            end else if (GAP > 0) begin
               w_state = S_GAP;
               w_pend  = w_q;
            end else begin
               w_state = w_q;
            end
         end
      end
   end

   // Instruction for the step being entered; registered on the same edge as the state.
   always_comb begin
      w_dec = '0;
      w_qk  = '0;
      w_pm  = '0;
      case (w_state)
         S_KLOAD: begin
            w_dec[6] = 1'b1;
            if (w_cnt >= 16'd1 && w_cnt <= L_COL) w_dec[3] = 1'b1;
            if (w_cnt >= 16'd2 && w_cnt <= L_COL) w_qk = 4'(w_cnt - 16'd2);
         end
         S_EXEC: begin
            w_dec[7] = 1'b1;
            w_dec[5] = 1'b1;
            w_qk     = 4'(w_cnt);
         end
         S_OFIFO: begin
            w_dec[16] = 1'b1;
            w_dec[0]  = 1'b1;
            w_pm      = 4'(w_cnt);
         end
         S_SFP: begin
            w_pm = 4'(w_cnt);
            case (w_slot)
               3'd0, 3'd2: w_dec[1] = 1'b1;
               3'd1: begin w_dec[1] = 1'b1; w_dec[17] = 1'b1; end
               3'd3: begin w_dec[1] = 1'b1; w_dec[18] = 1'b1; end
               3'd4: w_dec[0] = 1'b1;
               3'd5: w_dec[19] = 1'b1;
               default: w_dec[1] = 1'b0;
            endcase
         end
         default: w_dec = '0;
      endcase
      w_dec[15:12] = w_qk;
      w_dec[11:8]  = w_pm;
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= S_IDLE;
         r_pend  <= S_IDLE;
         r_cnt   <= '0;
         r_slot  <= '0;
         r_en    <= '0;
         r_n     <= '0;
         r_inst  <= '0;
      end else begin
         r_state <= w_state;
         r_pend  <= w_pend;
         r_cnt   <= w_cnt;
         r_slot  <= w_slot;
         r_en    <= w_en;
         r_n     <= w_n;
         r_inst  <= w_hold ? '0 : w_dec;
      end
   end

   assign o_inst  = r_inst;
   assign o_busy  = (r_state != S_IDLE);
   assign o_done  = (r_state == S_DONE);
   assign o_state = r_state;

`ifdef SEQ_PERF_CNT_EN
   logic [15:0] r_cyc;
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset)                            r_cyc <= '0;
      else if (r_state == S_IDLE && i_start)   r_cyc <= '0;
      else if (r_state != S_IDLE && r_cyc != 16'hFFFF) r_cyc <= r_cyc + 16'd1;
   end
   assign o_cycle_cnt = r_cyc;
`endif

endmodule

// File: tb/tb_fullchip_inst_seq.sv
// tb/tb_fullchip_inst_seq.sv - bench for fullchip_inst_seq: queue-based program model plus literal checks
module tb_fullchip_inst_seq;
   localparam int COL = 8;
   localparam int GAP = 10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  phase_en = 4'h0;
   logic [4:0]  n_vec = 5'd0;
   logic        stall = 1'b0;
   logic [19:0] inst;
   logic        busy, done;
   logic [2:0]  state;
`ifdef SEQ_PERF_CNT_EN
   logic [15:0] cyc;
`endif

   int checks = 0;
   int errors = 0;

   fullchip_inst_seq #(.COL(COL), .ADDR_W(4), .GAP(GAP), .INST_W(20)) dut (
      .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_phase_en(phase_en),
      .i_n_vec(n_vec), .i_stall(stall), .o_inst(inst), .o_busy(busy),
      .o_done(done), .o_state(state)
`ifdef SEQ_PERF_CNT_EN
      , .o_cycle_cnt(cyc)
`endif
   );

   always #5 clk = ~clk;

   // Model: the whole sequence is expanded into a queue of {state, inst} steps at start.
   logic [22:0] mq[$];
   logic [2:0]  m_st = 3'd0;
   logic [19:0] m_inst = 20'd0;
   int          m_cyc = 0;
   logic [19:0] sfp_pat[6] = '{20'h00002, 20'h20002, 20'h00002, 20'h40002, 20'h00001, 20'h80000};

   task automatic push(input logic [2:0] st, input logic [19:0] ins);
      mq.push_back({st, ins});
   endtask

   task automatic build(input logic [3:0] en, input int n);
      int  nn;
      bit  first;
      logic [19:0] ins;
      nn = (n > 16) ? 16 : n;
      first = 1;
      for (int p = 0; p < 4; p++) begin
         if (en[p] && (p == 0 || nn > 0)) begin
            if (!first) for (int g = 0; g < GAP; g++) push(3'd5, 20'h0);
            first = 0;
            if (p == 0) begin
               for (int k = 0; k < COL + 2; k++) begin
                  ins = 20'h00040;
                  if (k >= 1 && k <= COL) ins = ins | 20'h00008;
                  if (k >= 2 && k <= COL) ins = ins | 20'((k - 2) << 12);
                  push(3'd1, ins);
               end
            end else if (p == 1) begin
               for (int i = 0; i < nn; i++) push(3'd2, 20'h000A0 | 20'(i << 12));
            end else if (p == 2) begin
               for (int i = 0; i < nn; i++) push(3'd3, 20'h10001 | 20'(i << 8));
            end else begin
               for (int i = 0; i < nn; i++)
                  for (int s = 0; s < 6; s++) push(3'd4, sfp_pat[s] | 20'(i << 8));
            end
         end
      end
      push(3'd6, 20'h0);
   endtask

   task automatic pop();
      logic [22:0] e;
      e = mq.pop_front();
      m_st = e[22:20];
      m_inst = e[19:0];
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         m_st = 3'd0;
         m_inst = 20'h0;
         m_cyc = 0;
      end else begin
         if (m_st != 3'd0 && m_cyc < 65535) m_cyc = m_cyc + 1;
         if (m_st == 3'd0) begin
            m_inst = 20'h0;
            if (start) begin
               mq.delete();
               build(phase_en, int'(n_vec));
               m_cyc = 0;
               pop();
            end
         end else if (m_st == 3'd6) begin
            m_st = 3'd0;
            m_inst = 20'h0;
         end else if (stall) begin
            m_inst = 20'h0;
         end else begin
            pop();
         end
      end
   end

   always @(negedge clk) begin
      checks++;
      if (inst !== m_inst || state !== m_st || busy !== (m_st != 3'd0) || done !== (m_st == 3'd6)) begin
         errors++;
         $display("FAIL cycle t=%0t: inst=%05h state=%0d busy=%b done=%b, expected inst=%05h state=%0d",
                  $time, inst, state, busy, done, m_inst, m_st);
      end
`ifdef SEQ_PERF_CNT_EN
      checks++;
      if (cyc !== 16'(m_cyc)) begin
         errors++;
         $display("FAIL cycle_cnt t=%0t: got %0d expected %0d", $time, cyc, m_cyc);
      end
`endif
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   logic [19:0] cap[512];

   task automatic run(input logic [3:0] en, input int n, input int st_at, input int st_len,
                      input bit rnd, input int sb_at, input bit sd, output int len);
      int dn;
      @(negedge clk);
      phase_en = en;
      n_vec = 5'(n);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      len = 0;
      dn = 0;
      while (busy && len < 3000) begin
         if (len < 512) cap[len] = inst;
         if (done) dn++;
         stall = (len >= st_at && len < st_at + st_len) || (rnd && ($urandom % 6 == 0));
         start = (len == sb_at) || (sd && done);
         len++;
         @(negedge clk);
      end
      stall = 1'b0;
      start = 1'b0;
      chk("seq_timeout", 32'(len < 3000), 32'd1);
      chk("done_pulses", 32'(dn), 32'd1);
      @(negedge clk);
      chk("idle_after_done", 32'(busy), 32'd0);
   endtask

   int len;
   int qk_exp[10] = '{0, 0, 0, 1, 2, 3, 4, 5, 6, 0};

   initial begin
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("reset_inst", 32'(inst), 32'd0);
      chk("reset_state", 32'(state), 32'd0);
      @(negedge clk);
      #1 rst_n = 1'b1;

      // KLOAD only
      run(4'h1, 0, -1, 0, 0, -1, 0, len);
      chk("kload_len", 32'(len), 32'd11);
      for (int k = 0; k < 10; k++) begin
         chk("kload_load", 32'(cap[k][6]), 32'd1);
         chk("kload_kmem_rd", 32'(cap[k][3]), 32'((k >= 1 && k <= 8) ? 1 : 0));
         chk("kload_qk", 32'(cap[k][15:12]), 32'(qk_exp[k]));
      end
      chk("kload_done_inst", 32'(cap[10]), 32'd0);

      // full flow, start pulsed while busy
      run(4'hF, 8, -1, 0, 0, 30, 0, len);
      chk("full_len", 32'(len), 32'd105);
      chk("full_exec_last", 32'(cap[27]), 32'h070A0);
      chk("full_ofifo_first", 32'(cap[38]), 32'h10001);
      chk("full_sfp_s3_i7", 32'(cap[56 + 42 + 3]), 32'h40702);
`ifdef SEQ_PERF_CNT_EN
      chk("perf_full", 32'(cyc), 32'd105);
`endif

      // n_vec=0 with vector phases only; start held into the DONE cycle
      run(4'hE, 0, -1, 0, 0, -1, 1, len);
      chk("nvec0_len", 32'(len), 32'd1);
      chk("nvec0_inst", 32'(cap[0]), 32'd0);

      // clamp 20 -> 16
      run(4'h2, 20, -1, 0, 0, -1, 0, len);
      chk("clamp_len", 32'(len), 32'd17);
      chk("clamp_last", 32'(cap[15]), 32'h0F0A0);

      // stall 3 cycles at EXEC i=4
      run(4'h2, 8, 3, 3, 0, -1, 0, len);
      chk("stall_len", 32'(len), 32'd12);
      chk("stall_z0", 32'(cap[4]), 32'd0);
      chk("stall_z2", 32'(cap[6]), 32'd0);
      chk("stall_reissue", 32'(cap[7]), 32'h040A0);

      // reset during SFP slot 2
      @(negedge clk);
      phase_en = 4'hF;
      n_vec = 5'd8;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 58 && busy; c++) @(negedge clk);
      chk("sfp_slot2", 32'(inst), 32'h00002);
      #1 rst_n = 1'b0;
      #1;
      chk("async_inst", 32'(inst), 32'd0);
      chk("async_busy", 32'(busy), 32'd0);
      chk("async_done", 32'(done), 32'd0);
`ifdef SEQ_PERF_CNT_EN
      chk("perf_reset", 32'(cyc), 32'd0);
`endif
      @(negedge clk);
      #1 rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("no_done_after_reset", 32'(done | busy), 32'd0);
      end
      run(4'hF, 8, -1, 0, 0, -1, 0, len);
      chk("rerun_len", 32'(len), 32'd105);

      // randomized sequences checked by the model
      for (int r = 0; r < 25; r++)
         run(4'($urandom % 16), int'($urandom % 21), -1, 0, 1, int'($urandom % 40), 1'($urandom % 2), len);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fullchip_inst_seq.md
Name: fullchip_inst_seq

Overview:
- Hardware instruction sequencer that drives the 20-bit fullchip instruction word. It replaces bench-driven stimulus for the compute phases: K load, Q execute, ofifo-to-pmem move, and SFP normalization.
- The host first fills qmem/kmem through the existing write path, then pulses start.
- The block is parametrised in column count, vector count and inter-phase gap.
- It adds behaviour the bench flow lacks: per-phase enable, a runtime vector count, stall, and a done handshake.

Parameters:
- COL, 8: dot-product columns; the K load length derives from it.
- ADDR_W, 4: qkmem_add/pmem_add width; max vectors is 2^ADDR_W.
- GAP, 10: idle cycles (inst=0) inserted between consecutive enabled phases; 0 is legal.
- INST_W, 20: instruction width; fixed field map below.

Ports:
- clk  in  1  clock, all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin sequence; sampled in IDLE only.
- phase_en  in  4  [0]=KLOAD, [1]=EXEC, [2]=OFIFO, [3]=SFP; latched at start.
- n_vec  in  ADDR_W+1  vectors to process; latched at start; clamped to 2^ADDR_W.
- stall  in  1  freeze sequence; inst forced to 0 while high.
- inst  out  INST_W  registered instruction word.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse after the last instruction.
- state  out  3  current FSM state encoding.

Behaviour:
- inst field map:
  - [19] fifo_ext_rd, [18] div, [17] acc, [16] ofifo_rd.
  - [15:12] qkmem_add, [11:8] pmem_add.
  - [7] execute, [6] load, [5] qmem_rd, [4] qmem_wr, [3] kmem_rd, [2] kmem_wr, [1] pmem_rd, [0] pmem_wr.
  - The block never asserts qmem_wr or kmem_wr.
- Reset (asynchronous, active-low): inst=0, busy=0, done=0, state=IDLE, all counters 0. Reset mid-sequence aborts immediately with no done pulse.
- FSM states: IDLE(0), KLOAD(1), EXEC(2), OFIFO(3), SFP(4), GAP(5), DONE(6).
- IDLE:
  - start=1 latches phase_en and n_vec (clamped), then moves to the first enabled phase.
  - If no phase is enabled, or only vector phases are enabled with n_vec=0, go to DONE.
  - inst is registered, so the first instruction appears on the edge after start is sampled.
- KLOAD: COL+2 cycles, index k=0..COL+1.
  - load=1 on every cycle.
  - kmem_rd=1 for 1<=k<=COL.
  - qkmem_add = k-2 for 2<=k<=COL, else 0.
- EXEC: n_vec cycles, i=0..n_vec-1: execute=1, qmem_rd=1, qkmem_add=i.
- OFIFO: n_vec cycles: ofifo_rd=1, pmem_wr=1, pmem_add=i.
- SFP: n_vec slots of 6 cycles each, pmem_add=i throughout the slot.
  - s0: pmem_rd.
  - s1: pmem_rd, acc.
  - s2: pmem_rd.
  - s3: pmem_rd, div.
  - s4: pmem_wr.
  - s5: fifo_ext_rd.
- Vector phases with n_vec=0 are skipped.
- GAP: GAP cycles of inst=0, entered between enabled phases only. It is not entered after the last phase or when GAP=0.
- DONE: inst=0 and done=1 for one cycle, then IDLE; busy drops in the same cycle.
- stall:
  - inst=0 and all counters/state are held in the cycle stall is high.
  - On release, the held step is issued with no step lost or repeated.
  - Stall in IDLE or DONE has no effect.
- start while busy is ignored. start in the DONE cycle is ignored.
- Address counters wrap only via the clamp; n_vec=2^ADDR_W reaches address 2^ADDR_W-1.

Optional Feature:
- Macro: SEQ_PERF_CNT_EN.
- With the macro defined:
  - Extra output port cycle_cnt (16 bits).
  - Cleared at accepted start; increments every busy cycle including stalled ones; saturates at 16'hFFFF.
  - Holds its value after done until the next start; reset clears it to 0.
- Without the macro: the port and counter do not exist, with no other behavioural difference.

Test Plan:
- KLOAD only, COL=8, start → 10 cycles load=1:
  - kmem_rd set in cycles 1..8.
  - qkmem_add 0,0,0,1..6,0.
  - done pulse on the cycle after the last load; busy high for 11 cycles.
- Full flow, phase_en=4'hF, n_vec=8, GAP=10:
  - Total busy = 10+10+8+10+8+10+48+1 = 105 cycles.
  - EXEC qkmem_add 0..7, OFIFO pmem_add 0..7.
  - SFP slot pattern matches s0–s5 for each i.
- n_vec=0 with phase_en=4'hE → done one cycle after start with no nonzero inst. n_vec=20 with ADDR_W=4 → clamped to 16 EXEC cycles, address 15 last.
- stall high for 3 cycles at EXEC i=4 → inst=0 for 3 cycles, then i=4 reissued; total length +3. start pulsed while busy is ignored.
- Assert reset during SFP slot 2 → inst=0, busy=0 asynchronously, no done pulse; a new start afterwards runs from the first phase.
- With SEQ_PERF_CNT_EN, full flow as above → cycle_cnt=105 held after done; it reads 0 after reset.
